// File: rtl/ahb_lite_pkg.sv
// AHB-Lite bus encodings and the instruction-memory slave state type.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  // Data-phase state of the instruction-memory slave.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } imem_state_e;

endpackage

// File: rtl/ahb_sram_array.sv
// Word-wide SRAM with one synchronous read port and one synchronous write port.
// Latency: read data appears one edge after re_i; writes land at the edge.
// Backpressure: none; both ports accept every cycle.
module ahb_sram_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Write port: storage carries no reset so program contents survive it.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read port: registered output, holds between reads, cleared by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_lite_imem_slave.sv
// AHB-Lite instruction-memory slave: word reads/writes with programmable wait states.
// Latency: HREADYOUT high in data-phase cycle 1+wait; errors take exactly two cycles.
// Backpressure: HREADYOUT low during WAIT and ERR1; new address phases only taken when ready.
module ahb_lite_imem_slave
  import ahb_lite_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NSEQ_WAIT = 1,
  parameter int unsigned SEQ_WAIT  = 0
) (
  input  logic        HCLK_i,
  input  logic        HRESET_i,
  input  logic        HSEL_i,
  input  logic [31:0] HADDR_i,
  input  logic [1:0]  HTRANS_i,
  input  logic [2:0]  HBURST_i,
  input  logic [2:0]  HSIZE_i,
  input  logic        HWRITE_i,
  input  logic [31:0] HWDATA_i,
  input  logic        HREADY_i,
  output logic [31:0] HRDATA_o,
  output logic        HREADYOUT_o,
  output logic        HRESP_o
);

  localparam int unsigned DEPTH = MEM_BYTES / 4;
  localparam int          WW    = $clog2(DEPTH);

  imem_state_e   state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [WW-1:0] idx_q, idx_d;
  logic          wr_q, wr_d;
  logic          byp_q;
  logic [31:0]   byp_dat_q;

  logic [31:0]   off;
  logic          can_accept, accept, addr_err;
  logic [2:0]    acc_wait;
  logic [WW-1:0] acc_idx, rd_idx;
  logic          rd_en, wr_en, byp_hit;
  logic [31:0]   sram_rdata;

  // Burst type is informational only; SEQ addresses are used as presented.
  logic unused_hburst;
  assign unused_hburst = ^HBURST_i;

  assign off        = HADDR_i - BASE_ADDR;
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
  assign accept     = can_accept & HSEL_i & HREADY_i & HTRANS_i[1];
  assign addr_err   = (HSIZE_i != HSIZE_WORD) || (HADDR_i[1:0] != 2'b00) ||
                      (off >= 32'(MEM_BYTES));
  assign acc_wait   = (HTRANS_i == HTRANS_SEQ) ? 3'(SEQ_WAIT) : 3'(NSEQ_WAIT);
  assign acc_idx    = off[WW+1:2];

  // A write commits at the edge that closes its single DATA cycle.
  assign wr_en   = (state_q == ST_DATA) && wr_q;
  assign byp_hit = rd_en && wr_en && (rd_idx == idx_q);

  // Next state, wait countdown and read-issue decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    rd_en   = 1'b0;
    rd_idx  = idx_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = ST_DATA;
          rd_en   = !wr_q;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (accept) begin
          idx_d = acc_idx;
          wr_d  = HWRITE_i;
          if (addr_err) begin
            state_d = ST_ERR1;
          end else if (acc_wait != 3'd0) begin
            state_d = ST_WAIT;
            cnt_d   = acc_wait;
          end else begin
            state_d = ST_DATA;
            rd_en   = !HWRITE_i;
            rd_idx  = acc_idx;
          end
        end
      end
    endcase
  end

  // State register and captured transfer attributes.
  always_ff @(posedge HCLK_i or posedge HRESET_i) begin
    if (HRESET_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
    end
  end

  // Read-after-write bypass: remember whether the last read took HWDATA.
  always_ff @(posedge HCLK_i or posedge HRESET_i) begin
    if (HRESET_i) begin
      byp_q     <= 1'b0;
      byp_dat_q <= '0;
    end else if (rd_en) begin
      byp_q     <= byp_hit;
      byp_dat_q <= HWDATA_i;
    end
  end

  ahb_sram_array #(
    .DEPTH (DEPTH)
  ) u_sram (
    .clk_i   (HCLK_i),
    .rst_i   (HRESET_i),
    .re_i    (rd_en),
    .raddr_i (rd_idx),
    .rdata_o (sram_rdata),
    .we_i    (wr_en),
    .waddr_i (idx_q),
    .wdata_i (HWDATA_i)
  );

  assign HRDATA_o    = byp_q ? byp_dat_q : sram_rdata;
  assign HREADYOUT_o = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
  assign HRESP_o     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: tb/tb_ahb_lite_imem_slave.sv
// Randomized bench for the AHB-Lite instruction-memory slave against a transfer-level model.
// Latency: model predicts ready/response/read data per data-phase cycle.
// Backpressure: the bench master holds each address phase until the modelled ready.
module tb_ahb_lite_imem_slave;
  import ahb_lite_pkg::*;

  localparam int          MEM_BYTES = 4096;
  localparam int          WORDS     = MEM_BYTES / 4;
  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam int          NSEQ_W    = 1;
  localparam int          SEQ_W     = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = HTRANS_IDLE;
  logic [2:0]  hburst = HBURST_SINGLE;
  logic [2:0]  hsize = HSIZE_WORD;
  logic        hwrite = 1'b0;
  logic [31:0] hwdata = '0;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  assign hready = hreadyout;

  ahb_lite_imem_slave #(
    .MEM_BYTES (MEM_BYTES),
    .BASE_ADDR (BASE),
    .NSEQ_WAIT (NSEQ_W),
    .SEQ_WAIT  (SEQ_W)
  ) dut (
    .HCLK_i      (clk),
    .HRESET_i    (rst),
    .HSEL_i      (hsel),
    .HADDR_i     (haddr),
    .HTRANS_i    (htrans),
    .HBURST_i    (hburst),
    .HSIZE_i     (hsize),
    .HWRITE_i    (hwrite),
    .HWDATA_i    (hwdata),
    .HREADY_i    (hready),
    .HRDATA_o    (hrdata),
    .HREADYOUT_o (hreadyout),
    .HRESP_o     (hresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t q[$];
  xfer_t drv;

  // Reference model: memory image plus the data phase currently in flight.
  logic [31:0] mem_m [WORDS];
  logic [31:0] last_rd;
  int          dp_kind;  // 0 = no transfer, 1 = OKAY transfer, 2 = ERROR transfer
  int          dp_wait;
  int          dp_idx;
  logic        dp_wr;
  logic [31:0] dp_wdata;
  int          k;
  logic        prev_ready;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic xfer_t mk(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                               input logic [2:0] size, input logic wr, input logic [31:0] wdata);
    xfer_t x;
    x.sel = sel; x.trans = trans; x.addr = addr; x.size = size; x.wr = wr; x.wdata = wdata;
    return x;
  endfunction

  function automatic xfer_t idle_x();
    return mk(1'b0, HTRANS_IDLE, 32'h0, HSIZE_WORD, 1'b0, 32'h0);
  endfunction

  function automatic xfer_t rand_xfer();
    xfer_t x;
    int r;
    x.sel = ($urandom_range(0, 99) >= 8);
    r = $urandom_range(0, 99);
    x.trans = (r < 10) ? HTRANS_IDLE : (r < 18) ? HTRANS_BUSY : (r < 55) ? HTRANS_NONSEQ : HTRANS_SEQ;
    r = $urandom_range(0, 99);
    if (r < 75)      x.addr = 32'($urandom_range(0, 63)) << 2;
    else if (r < 85) x.addr = 32'($urandom_range(0, WORDS - 1)) << 2;
    else if (r < 92) x.addr = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
    else             x.addr = BASE + MEM_BYTES + (32'($urandom_range(0, 255)) << 2);
    x.size  = ($urandom_range(0, 99) < 90) ? HSIZE_WORD : 3'($urandom_range(0, 1));
    x.wr    = ($urandom_range(0, 99) < 40);
    x.wdata = $urandom;
    return x;
  endfunction

  task automatic drive_pins();
    hsel   = drv.sel;
    htrans = drv.trans;
    haddr  = drv.addr;
    hsize  = drv.size;
    hwrite = drv.wr;
    hburst = (drv.trans == HTRANS_SEQ) ? HBURST_INCR4 : HBURST_SINGLE;
  endtask

  // One bus cycle: retire/start data phases per the model, then compare outputs.
  task automatic step();
    logic exp_rdy;
    logic exp_resp;
    @(negedge clk);
    if (prev_ready) begin
      if (dp_kind == 1 && dp_wr) mem_m[dp_idx] = dp_wdata;
      dp_kind = 0;
      if (drv.sel && drv.trans[1]) begin
        dp_wr    = drv.wr;
        dp_wdata = drv.wdata;
        if (drv.size != HSIZE_WORD || drv.addr[1:0] != 2'b00 ||
            drv.addr < BASE || drv.addr >= BASE + MEM_BYTES) begin
          dp_kind = 2;
        end else begin
          dp_kind = 1;
          dp_idx  = int'((drv.addr - BASE) >> 2);
          dp_wait = (drv.trans == HTRANS_SEQ) ? SEQ_W : NSEQ_W;
        end
      end
      k      = 0;
      hwdata = drv.wdata;
      if (q.size() != 0) drv = q.pop_front();
      else               drv = idle_x();
      drive_pins();
    end else begin
      k++;
    end
    exp_rdy  = 1'b1;
    exp_resp = HRESP_OKAY;
    if (dp_kind == 2) begin
      exp_resp = HRESP_ERROR;
      exp_rdy  = (k >= 1);
    end else if (dp_kind == 1) begin
      exp_rdy = (k >= dp_wait);
      if (exp_rdy && !dp_wr) last_rd = mem_m[dp_idx];
    end
    chk("hreadyout", 32'(hreadyout), 32'(exp_rdy));
    chk("hresp", 32'(hresp), 32'(exp_resp));
    chk("hrdata", hrdata, last_rd);
    prev_ready = exp_rdy;
  endtask

  task automatic drain();
    while (q.size() != 0) step();
    repeat (20) step();
  endtask

  task automatic model_reset();
    dp_kind    = 0;
    k          = 0;
    prev_ready = 1'b1;
    last_rd    = '0;
    drv        = idle_x();
    drive_pins();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_hreadyout", 32'(hreadyout), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'h0);
    rst = 1'b0;

    // Loader fills the whole memory with one NONSEQ and a run of zero-wait SEQ writes.
    q.push_back(mk(1'b1, HTRANS_NONSEQ, BASE, HSIZE_WORD, 1'b1, $urandom));
    for (int i = 1; i < WORDS; i++)
      q.push_back(mk(1'b1, HTRANS_SEQ, BASE + 32'(i * 4), HSIZE_WORD, 1'b1,
                     (i == 4) ? 32'hDEADBEEF : $urandom));
    drain();

    // Single NONSEQ read with one wait state.
    q.push_back(mk(1'b1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1'b0, 32'h0));
    drain();
    chk("read_0x10", hrdata, 32'hDEADBEEF);

    // INCR4 burst of reads.
    q.push_back(mk(1'b1, HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 1'b0, 32'h0));
    q.push_back(mk(1'b1, HTRANS_SEQ, 32'h24, HSIZE_WORD, 1'b0, 32'h0));
    q.push_back(mk(1'b1, HTRANS_SEQ, 32'h28, HSIZE_WORD, 1'b0, 32'h0));
    q.push_back(mk(1'b1, HTRANS_SEQ, 32'h2C, HSIZE_WORD, 1'b0, 32'h0));
    drain();

    // Write immediately followed by a zero-wait read of the same word.
    q.push_back(mk(1'b1, HTRANS_NONSEQ, 32'h40, HSIZE_WORD, 1'b1, 32'h12345678));
    q.push_back(mk(1'b1, HTRANS_SEQ, 32'h40, HSIZE_WORD, 1'b0, 32'h0));
    drain();
    chk("bypass_0x40", hrdata, 32'h12345678);
    q.push_back(mk(1'b1, HTRANS_SEQ, 32'h44, HSIZE_WORD, 1'b1, 32'hCAFEF00D));
    q.push_back(mk(1'b1, HTRANS_SEQ, 32'h44, HSIZE_WORD, 1'b0, 32'h0));
    drain();

    // Error transfers back to back, then confirm memory untouched.
    q.push_back(mk(1'b1, HTRANS_NONSEQ, 32'h1002, HSIZE_WORD, 1'b0, 32'h0));
    q.push_back(mk(1'b1, HTRANS_NONSEQ, BASE + MEM_BYTES, HSIZE_WORD, 1'b0, 32'h0));
    q.push_back(mk(1'b1, HTRANS_NONSEQ, 32'h42, HSIZE_WORD, 1'b1, 32'hBADBAD00));
    q.push_back(mk(1'b1, HTRANS_SEQ, 32'h44, 3'b000, 1'b1, 32'hBADBAD01));
    q.push_back(mk(1'b1, HTRANS_NONSEQ, BASE + MEM_BYTES, HSIZE_WORD, 1'b1, 32'hBADBAD02));
    q.push_back(mk(1'b1, HTRANS_NONSEQ, 32'h40, HSIZE_WORD, 1'b0, 32'h0));
    q.push_back(mk(1'b1, HTRANS_SEQ, 32'h44, HSIZE_WORD, 1'b0, 32'h0));
    drain();
    chk("err_mem_0x44", hrdata, 32'hCAFEF00D);

    // IDLE, BUSY and unselected cycles between reads.
    q.push_back(mk(1'b1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1'b0, 32'h0));
    q.push_back(mk(1'b1, HTRANS_IDLE, 32'h14, HSIZE_WORD, 1'b0, 32'h0));
    q.push_back(mk(1'b1, HTRANS_SEQ, 32'h14, HSIZE_WORD, 1'b0, 32'h0));
    q.push_back(mk(1'b1, HTRANS_BUSY, 32'h18, HSIZE_WORD, 1'b0, 32'h0));
    q.push_back(mk(1'b0, HTRANS_NONSEQ, 32'h18, HSIZE_WORD, 1'b1, 32'h0BAD0BAD));
    q.push_back(mk(1'b1, HTRANS_NONSEQ, 32'h18, HSIZE_WORD, 1'b0, 32'h0));
    drain();

    // Reset asserted while a write sits in its wait state: nothing commits.
    q.push_back(mk(1'b1, HTRANS_NONSEQ, 32'h80, HSIZE_WORD, 1'b1, 32'hA5A5A5A5));
    step();
    step();
    rst = 1'b1;
    drv = idle_x();
    drive_pins();
    #1;
    chk("midrst_hreadyout", 32'(hreadyout), 32'd1);
    chk("midrst_hresp", 32'(hresp), 32'd0);
    chk("midrst_hrdata", hrdata, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    q.push_back(mk(1'b1, HTRANS_NONSEQ, 32'h80, HSIZE_WORD, 1'b0, 32'h0));
    drain();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) q.push_back(rand_xfer());
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_lite_imem_slave.md
# ahb_lite_imem_slave

AHB-Lite slave that serves the instruction cache's fetch traffic (single NONSEQ reads and INCR4 SEQ bursts) from an on-chip word-addressed memory, with configurable wait states and a two-cycle ERROR response. Write transfers are accepted so that a loader master can fill program memory. It sits behind the AHB-Lite decoder/mux, on the opposite end of the bus from the cache controller.

## Interface
- MEM_BYTES, 4096, memory size in bytes (power of two, ≥16)
- BASE_ADDR, 32'h0000_0000, first byte address decoded by this slave (aligned to MEM_BYTES)
- NSEQ_WAIT, 1, wait cycles inserted for a NONSEQ data phase (0..7)
- SEQ_WAIT, 0, wait cycles inserted for a SEQ data phase (0..7)
- HCLK  in  1  bus clock; all state on its rising edge
- HRESET  in  1  asynchronous, active-high reset
- HSEL  in  1  slave select from decoder
- HADDR  in  32  transfer address
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
- HBURST  in  3  burst type (informational only)
- HSIZE  in  3  transfer size
- HWRITE  in  1  1 = write
- HWDATA  in  32  write data (data phase)
- HREADY  in  1  bus-wide ready from mux
- HRDATA  out  32  read data
- HREADYOUT  out  1  this slave's ready
- HRESP  out  1  0 = OKAY, 1 = ERROR

## Operation
- Accept an address phase when HSEL & HREADY & HTRANS[1] at a rising edge. Otherwise (IDLE, BUSY, unselected) the next data phase is zero-wait OKAY.
- Error check at acceptance: HSIZE≠3'b010, HADDR[1:0]≠0, or HADDR outside [BASE_ADDR, BASE_ADDR+MEM_BYTES). Error → ERROR response; no memory access.
- States: IDLE (HREADYOUT=1, HRESP=0); WAIT (countdown, HREADYOUT=0); DATA (HREADYOUT=1, last data cycle); ERR1 (HREADYOUT=0, HRESP=1); ERR2 (HREADYOUT=1, HRESP=1).
- Transitions on acceptance: OK with wait>0 → WAIT loaded with NSEQ_WAIT/SEQ_WAIT per HTRANS; OK with wait=0 → DATA; error → ERR1. WAIT → DATA when counter reaches 1. ERR1 → ERR2. DATA/ERR2/IDLE → next acceptance or IDLE.
- Pipelined: a new address phase is accepted in the DATA or ERR2 cycle (HREADY high). A master cancelling after ERR1 (HTRANS=IDLE in ERR2) returns the slave to IDLE.
- Reads: memory read is issued at the edge that leaves the final WAIT cycle (or at acceptance if wait=0), so HRDATA is registered and valid throughout DATA. HRDATA holds its last value otherwise.
- Writes: HWDATA is committed at the edge that ends DATA, at word index (HADDR−BASE_ADDR)>>2, MSBs truncated to $clog2(MEM_BYTES/4).
- Read-after-write bypass: if a read is issued at the same edge a write to the same word commits, HRDATA takes HWDATA.
- HBURST is not checked. SEQ addresses are used exactly as presented.

## Timing
- Reset: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, wait counter 0. Memory contents are not cleared.
- Reset mid-transfer aborts it with no write commit. The first edge after release may accept a transfer.
- Read latency from acceptance edge: HREADYOUT high in cycle 1+wait. Back-to-back zero-wait SEQ gives 1 word per cycle.
- Error: exactly 2 data-phase cycles (ERR1, ERR2), regardless of wait parameters.

## Structure
- Shared package ahb_lite_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HSIZE_WORD, HRESP_OKAY/ERROR, HBURST encodings, and this block's state enum.
- One sub-module ahb_sram_array (parameterised depth; one sync read port, one sync write port). Bypass logic stays in the top.

## Test plan
- Reset: assert HRESET mid-WAIT → HREADYOUT=1, HRESP=0, HRDATA=0 immediately; no write committed.
- NONSEQ read 0x10 with NSEQ_WAIT=1, mem[4]=0xDEADBEEF → HREADYOUT low 1 cycle, then high with HRDATA=0xDEADBEEF.
- INCR4 from 0x20 (NONSEQ + 3 SEQ), SEQ_WAIT=0, NSEQ_WAIT=0 → 4 consecutive ready cycles returning mem[8..11].
- Write 0x40=0x12345678 immediately followed by read 0x40 → read returns 0x12345678 via bypass.
- Read 0x1002 (misaligned), then read at BASE_ADDR+MEM_BYTES → each gives ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (1,1), with memory unchanged.
- IDLE/BUSY and HSEL=0 cycles interleaved with reads → zero-wait OKAY, no state change.
